// File: rtl/run_sequencer_if.sv
// run_sequencer_if: the handshake and monitor signals between the run
// sequencer, the host and the program counter / datapath.
//
// Parameters:
//   PC_W   width of the monitored PC value
//   CNT_W  width of the run-cycle counter
//
// Signals:
//   start      host run request, level-sampled
//   halt_req   decoded halt instruction from the control unit
//   pc         current PC value
//   done_ack   host acknowledge of done
//   pc_init    drives the PC init input
//   pc_halt    drives the PC halt input
//   busy       high while initialising or running
//   done       high while waiting for the host acknowledge
//   cycle_cnt  RUN cycles of the last or current run
//   timeout    last run was ended by the watchdog
//
// Modports:
//   master  host / datapath side (drives requests, observes status)
//   slave   the sequencer itself
interface run_sequencer_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             halt_req;
    logic [PC_W-1:0]  pc;
    logic             done_ack;
    logic             pc_init;
    logic             pc_halt;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;
    logic             timeout;

    modport master (
        output start, halt_req, pc, done_ack,
        input  pc_init, pc_halt, busy, done, cycle_cnt, timeout
    );

    modport slave (
        input  start, halt_req, pc, done_ack,
        output pc_init, pc_halt, busy, done, cycle_cnt, timeout
    );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: top-level execution controller for the program counter and
// the single-cycle datapath. A host start holds the PC in init for
// INIT_CYCLES cycles, then the program runs until a halt instruction, the
// end-of-program PC or (optionally) a watchdog limit. The PC is frozen, done
// is reported with the run-cycle count, and the sequencer waits for the host
// acknowledge before returning to idle.
//
// Optional feature: define WATCHDOG_EN to end a run after WDOG_LIMIT RUN
// cycles and report it on timeout. Without it timeout is tied to 0.
//
// Parameters:
//   INIT_CYCLES  cycles pc_init is held after start (legal 1..15)
//   PC_W         width of the monitored PC
//   PROG_END     PC value that ends the program
//   CNT_W        width of the run-cycle counter
//   WDOG_LIMIT   RUN-cycle limit (WATCHDOG_EN only)
//
// Ports:
//   CLK     system clock, rising edge
//   init_n  asynchronous active-low reset
//   bus     run_sequencer_if slave modport (start/halt_req/pc/done_ack in,
//           pc_init/pc_halt/busy/done/cycle_cnt/timeout out)
module run_sequencer #(
    parameter int unsigned     INIT_CYCLES = 2,
    parameter int unsigned     PC_W        = 10,
    parameter logic [PC_W-1:0] PROG_END    = 10'h3FF,
    parameter int unsigned     CNT_W       = 16,
    parameter int unsigned     WDOG_LIMIT  = 16'hFFFF
) (
    input  logic               CLK,
    input  logic               init_n,
    run_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t           state;
    logic [3:0]       init_cnt;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic             timeout_q;

    logic at_end_pc;
    logic wdog_hit;
    logic end_cond;

    // The end PC is only meaningful in RUN; end_cond is qualified by state
    // wherever it is used.
    assign at_end_pc = (bus.pc == PROG_END);

`ifdef WATCHDOG_EN
    // Hit on the WDOG_LIMIT-th RUN cycle, so a run never exceeds the limit.
    assign wdog_hit = (state == RUN) && (cycle_cnt_q == CNT_W'(WDOG_LIMIT - 1));
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_hit          = 1'b0;
`endif

    assign end_cond = bus.halt_req | at_end_pc | wdog_hit;

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            state       <= IDLE;
            init_cnt    <= '0;
            cycle_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= INIT;
                        init_cnt    <= 4'(INIT_CYCLES - 1);
                        cycle_cnt_q <= '0;
                        timeout_q   <= 1'b0;
                    end
                end
                INIT: begin
                    if (init_cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        init_cnt <= init_cnt - 4'd1;
                    end
                end
                RUN: begin
                    // The terminating cycle is counted too; saturate, never wrap.
                    if (cycle_cnt_q != '1) begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                    if (end_cond) begin
                        state     <= DONE;
                        // halt instruction and end PC win over the watchdog.
                        timeout_q <= wdog_hit & ~bus.halt_req & ~at_end_pc;
                    end
                end
                DONE: begin
                    if (bus.done_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // pc_init follows state, so reset asserts it asynchronously.
    assign bus.pc_init   = (state == IDLE) || (state == INIT);
    assign bus.busy      = (state == INIT) || (state == RUN);
    assign bus.done      = (state == DONE);
    // Freeze the PC on the same edge that enters DONE.
    assign bus.pc_halt   = ((state == RUN) && end_cond) || (state == DONE);
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.timeout   = timeout_q;

endmodule
